// File: rtl/acc_tile_buffer_if.sv
// Handshake and streaming bus of the double-buffered accumulator tile buffer.
// The PE-array side drives the partial-sum row signals; the buffer drives
// the ready, the ppu start pulse, the streamed row and the bank status.
interface acc_tile_buffer_if #(
    parameter int LANES  = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24
);
    logic                     i_psum_valid;
    logic                     o_psum_ready;
    logic [3:0]               i_psum_row;
    logic                     i_psum_first;
    logic                     i_psum_last;
    logic [PSUM_W*LANES-1:0]  i_psum_data;
    logic                     o_ppu_start;
    logic [ACC_W*LANES-1:0]   o_acc_data;
    logic [1:0]               o_bank_full;

    // Producer of partial sums / consumer of the streamed tile
    modport master (
        output i_psum_valid, i_psum_row, i_psum_first, i_psum_last, i_psum_data,
        input  o_psum_ready, o_ppu_start, o_acc_data, o_bank_full
    );

    // The tile buffer itself
    modport slave (
        input  i_psum_valid, i_psum_row, i_psum_first, i_psum_last, i_psum_data,
        output o_psum_ready, o_ppu_start, o_acc_data, o_bank_full
    );
endinterface

// File: rtl/acc_tile_buffer.sv
// Double-buffered output accumulator between the PE array and the ppu.
// One bank accumulates signed partial-sum rows over K-passes with saturation
// while the other bank streams its finished tile: a one-cycle start pulse
// followed by 16 rows on 16 consecutive cycles.
module acc_tile_buffer #(
    parameter int LANES  = 16,
    parameter int ROWS   = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    acc_tile_buffer_if.slave bus
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILL,
        BANK_FULL,
        BANK_DRAIN
    } bank_state_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_START,
        DR_STREAM
    } drain_state_t;

    // Sign-extend one lane of partial sum to accumulator width
    function automatic logic signed [ACC_W-1:0] sext_psum(input logic signed [PSUM_W-1:0] v);
        return {{(ACC_W-PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

    // Add at ACC_W+1 bits and clamp to the signed ACC_W range
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    bank_state_t               bank_st [2];
    logic                      fill_ptr;
    logic                      drain_ptr;
    logic                      oth_ptr;
    drain_state_t              dr_st;
    drain_state_t              dr_st_nxt;
    logic [3:0]                row_k;

    // Tile storage; never reset, the first pass of each tile overwrites it
    logic signed [ACC_W-1:0]   acc_mem [2][ROWS][LANES];

    logic                      psum_ready;
    logic                      wr_vld_p0;
    logic                      wr_close_p0;
    logic signed [ACC_W-1:0]   wr_data_p0 [LANES];
    logic                      tile_rdy_cur;
    logic                      tile_rdy_oth;
    logic [ACC_W*LANES-1:0]    acc_data;
    logic [1:0]                bank_full;

    assign oth_ptr     = ~drain_ptr;
    // Ready depends on bank state only, so the producer may hold valid while waiting
    assign psum_ready  = (bank_st[fill_ptr] == BANK_EMPTY) || (bank_st[fill_ptr] == BANK_FILL);
    assign wr_vld_p0   = bus.i_psum_valid && psum_ready;
    assign wr_close_p0 = wr_vld_p0 && bus.i_psum_last && (bus.i_psum_row == LAST_ROW);

    // A bank is startable if already FULL or being closed on this very edge;
    // looking at the closing write lets the start pulse follow it by one cycle.
    assign tile_rdy_cur = (bank_st[drain_ptr] == BANK_FULL) || (wr_close_p0 && (fill_ptr == drain_ptr));
    assign tile_rdy_oth = (bank_st[oth_ptr] == BANK_FULL) || (wr_close_p0 && (fill_ptr == oth_ptr));

    // Stage p0: overwrite on the first pass, otherwise saturating accumulate
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            wr_data_p0[l] = bus.i_psum_first
                ? sext_psum(bus.i_psum_data[l*PSUM_W +: PSUM_W])
                : sat_add(acc_mem[fill_ptr][bus.i_psum_row][l],
                          sext_psum(bus.i_psum_data[l*PSUM_W +: PSUM_W]));
        end
    end

    // Stage p1: commit the accepted row into the fill bank
    always_ff @(posedge i_clk) begin
        if (wr_vld_p0) begin
            for (int l = 0; l < LANES; l++) begin
                acc_mem[fill_ptr][bus.i_psum_row][l] <= wr_data_p0[l];
            end
        end
    end

    // Bank lifecycle and fill/drain pointers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            fill_ptr   <= 1'b0;
            drain_ptr  <= 1'b0;
        end else begin
            if (wr_vld_p0) begin
                if (wr_close_p0) begin
                    bank_st[fill_ptr] <= BANK_FULL;
                    fill_ptr          <= ~fill_ptr;
                end else begin
                    bank_st[fill_ptr] <= BANK_FILL;
                end
            end
            if (dr_st == DR_START) begin
                bank_st[drain_ptr] <= BANK_DRAIN;
            end
            if ((dr_st == DR_STREAM) && (row_k == LAST_ROW)) begin
                bank_st[drain_ptr] <= BANK_EMPTY;
                drain_ptr          <= ~drain_ptr;
            end
        end
    end

    // Drain FSM state register and row counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dr_st <= DR_IDLE;
            row_k <= '0;
        end else begin
            dr_st <= dr_st_nxt;
            row_k <= (dr_st == DR_STREAM) ? row_k + 4'd1 : 4'd0;
        end
    end

    // Drain FSM next state; chaining straight into START keeps starts 17 cycles apart
    always_comb begin
        dr_st_nxt = dr_st;
        case (dr_st)
            DR_IDLE:   if (tile_rdy_cur) dr_st_nxt = DR_START;
            DR_START:  dr_st_nxt = DR_STREAM;
            DR_STREAM: begin
                if (row_k == LAST_ROW) begin
                    dr_st_nxt = tile_rdy_oth ? DR_START : DR_IDLE;
                end
            end
            default:   dr_st_nxt = DR_IDLE;
        endcase
    end

    // Streamed row is zero outside the 16 stream cycles
    always_comb begin
        acc_data = '0;
        if (dr_st == DR_STREAM) begin
            for (int l = 0; l < LANES; l++) begin
                acc_data[l*ACC_W +: ACC_W] = acc_mem[drain_ptr][row_k][l];
            end
        end
    end

    // Per-bank FULL-or-DRAIN status
    always_comb begin
        bank_full = '0;
        for (int b = 0; b < 2; b++) begin
            bank_full[b] = (bank_st[b] == BANK_FULL) || (bank_st[b] == BANK_DRAIN);
        end
    end

    assign bus.o_psum_ready = psum_ready;
    assign bus.o_ppu_start  = (dr_st == DR_START);
    assign bus.o_acc_data   = acc_data;
    assign bus.o_bank_full  = bank_full;

endmodule

// File: tb/tb_acc_tile_buffer.sv
// Testbench for acc_tile_buffer: scenario tasks drive partial-sum rows and
// push the expected streamed rows into a scoreboard queue; a negedge monitor
// pops and compares rows after each start pulse and requires zeros otherwise.
module tb_acc_tile_buffer;

    localparam int LANES  = 16;
    localparam int PSUM_W = 16;
    localparam int ACC_W  = 24;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   last_acc = 0;
    int   stream_left = 0;

    logic [ACC_W*LANES-1:0] exp_q[$];
    logic [ACC_W*LANES-1:0] exp_row;
    int                     start_q[$];

    acc_tile_buffer_if #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

    acc_tile_buffer #(.LANES(LANES), .ROWS(16), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: rows follow each start pulse on 16 consecutive cycles
    always @(negedge clk) begin
        if (mon_en) begin
            if (stream_left > 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_row: got %h with no row expected", bus.o_acc_data);
                end else begin
                    exp_row = exp_q.pop_front();
                    if (bus.o_acc_data !== exp_row) begin
                        errors++;
                        $display("FAIL stream_row cyc %0d: got %h expected %h", cyc, bus.o_acc_data, exp_row);
                    end
                end
                stream_left--;
            end else begin
                checks++;
                if (bus.o_acc_data !== '0) begin
                    errors++;
                    $display("FAIL idle_zero cyc %0d: got %h expected 0", cyc, bus.o_acc_data);
                end
            end
            if (bus.o_ppu_start === 1'b1) begin
                checks++;
                if (stream_left != 0) begin
                    errors++;
                    $display("FAIL start_overlap cyc %0d: got %0d rows pending expected 0", cyc, stream_left);
                end
                start_q.push_back(cyc);
                stream_left = 16;
            end
            if (rst === 1'b1) begin
                stream_left = 0;
                exp_q.delete();
            end
        end
    end

    function automatic logic [PSUM_W*LANES-1:0] psum_of(input int base, input int step);
        logic [PSUM_W*LANES-1:0] v;
        int x;
        for (int l = 0; l < LANES; l++) begin
            x = base + l * step;
            v[l*PSUM_W +: PSUM_W] = x[PSUM_W-1:0];
        end
        return v;
    endfunction

    function automatic logic [ACC_W*LANES-1:0] acc_of(input int base, input int step);
        logic [ACC_W*LANES-1:0] v;
        int x;
        for (int l = 0; l < LANES; l++) begin
            x = base + l * step;
            v[l*ACC_W +: ACC_W] = x[ACC_W-1:0];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one row; accepted at the end of the cycle where ready is high
    task automatic send_row(input int row, input logic first, input logic last,
                            input logic [PSUM_W*LANES-1:0] data);
        int guard;
        guard = 0;
        bus.i_psum_valid = 1'b1;
        bus.i_psum_row   = row[3:0];
        bus.i_psum_first = first;
        bus.i_psum_last  = last;
        bus.i_psum_data  = data;
        while (bus.o_psum_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready %b expected 1 within 100 cycles", bus.o_psum_ready);
        end
        last_acc = cyc;
        tick();
        bus.i_psum_valid = 1'b0;
    endtask

    task automatic wait_start(output int sc, output bit ok);
        ok = 1'b0;
        sc = -1;
        for (int i = 0; i < 60; i++) begin
            if (start_q.size() > 0) begin
                sc = start_q.pop_front();
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0 && stream_left == 0) begin
                ok = 1'b1;
                tick();
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        checks++;
        if (bus.o_ppu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.o_ppu_start); end
        checks++;
        if (bus.o_acc_data !== '0) begin errors++; $display("FAIL reset_acc: got %h expected 0", bus.o_acc_data); end
        checks++;
        if (bus.o_bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full: got %b expected 00", bus.o_bank_full); end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.o_psum_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.o_psum_ready); end
        checks++;
        if (bus.o_bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full_rel: got %b expected 00", bus.o_bank_full); end
    endtask

    task automatic test_single_pass();
        int sa;
        int w;
        bit ok;
        start_q.delete();
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(r * 16, 1));
            send_row(r, 1'b1, 1'b1, psum_of(r * 16, 1));
        end
        w = last_acc;
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != w + 1) begin errors++; $display("FAIL single_start: got cycle %0d expected %0d", sa, w + 1); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: got %0d rows left expected 0", exp_q.size()); end
    endtask

    task automatic test_multi_pass();
        int sa;
        int w;
        int r;
        bit ok;
        start_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(acc_of(300, 0));
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                r = (p == 1) ? 15 - i : i;
                send_row(r, p == 0, p == 2, psum_of(100, 0));
            end
        end
        w = last_acc;
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != w + 1) begin errors++; $display("FAIL multi_start: got cycle %0d expected %0d", sa, w + 1); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_drain: got %0d rows left expected 0", exp_q.size()); end
    endtask

    task automatic test_saturation();
        int sa;
        int w;
        bit ok;
        for (int t = 0; t < 2; t++) begin
            start_q.delete();
            for (int i = 0; i < 16; i++) exp_q.push_back(acc_of((t == 0) ? 8388607 : -8388608, 0));
            for (int p = 0; p < 300; p++) begin
                for (int r = 0; r < 16; r++) begin
                    send_row(r, p == 0, p == 299, psum_of((t == 0) ? 32767 : -32768, 0));
                end
            end
            w = last_acc;
            wait_start(sa, ok);
            checks++;
            if (!ok || sa != w + 1) begin errors++; $display("FAIL sat_start%0d: got cycle %0d expected %0d", t, sa, w + 1); end
            wait_drain(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL sat_drain%0d: got %0d rows left expected 0", t, exp_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        int wa;
        int sa;
        int sb;
        int rise;
        bit ok;
        start_q.delete();
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(r * 16 + 500, 1));
            send_row(r, 1'b1, 1'b1, psum_of(r * 16 + 500, 1));
        end
        wa = last_acc;
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(-(r * 16) - 1, -1));
            send_row(r, 1'b1, 1'b1, psum_of(-(r * 16) - 1, -1));
        end
        checks++;
        if (bus.o_psum_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low: got %b expected 0", bus.o_psum_ready); end
        checks++;
        if (bus.o_bank_full !== 2'b11) begin errors++; $display("FAIL b2b_bank_full: got %b expected 11", bus.o_bank_full); end
        rise = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_psum_ready === 1'b1) begin
                rise = cyc;
                break;
            end
            tick();
        end
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != wa + 1) begin errors++; $display("FAIL b2b_start_a: got cycle %0d expected %0d", sa, wa + 1); end
        checks++;
        if (rise != sa + 17) begin errors++; $display("FAIL b2b_ready_rise: got cycle %0d expected %0d", rise, sa + 17); end
        wait_start(sb, ok);
        checks++;
        if (!ok || sb != sa + 17) begin errors++; $display("FAIL b2b_start_gap: got %0d expected 17", sb - sa); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d rows left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_stream();
        int sa;
        int w;
        bit ok;
        start_q.delete();
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(2000 + r * 16, 3));
            send_row(r, 1'b1, 1'b1, psum_of(2000 + r * 16, 3));
        end
        w = last_acc;
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != w + 1) begin errors++; $display("FAIL rstm_start: got cycle %0d expected %0d", sa, w + 1); end
        for (int i = 0; i < 40 && cyc < sa + 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.o_acc_data !== '0) begin errors++; $display("FAIL rstm_acc: got %h expected 0", bus.o_acc_data); end
        checks++;
        if (bus.o_psum_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready: got %b expected 1", bus.o_psum_ready); end
        checks++;
        if (bus.o_bank_full !== 2'b00) begin errors++; $display("FAIL rstm_bank_full: got %b expected 00", bus.o_bank_full); end
        repeat (20) tick();
        checks++;
        if (start_q.size() != 0) begin errors++; $display("FAIL rstm_no_start: got %0d starts expected 0", start_q.size()); end
        start_q.delete();
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(40 + r * 32, 2));
            send_row(r, 1'b1, 1'b1, psum_of(40 + r * 32, 2));
        end
        w = last_acc;
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != w + 1) begin errors++; $display("FAIL rstm_new_start: got cycle %0d expected %0d", sa, w + 1); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstm_drain: got %0d rows left expected 0", exp_q.size()); end
    endtask

    task automatic test_close_on_row15();
        int wa;
        int wb;
        int sa;
        int sb;
        bit ok;
        start_q.delete();
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(acc_of(7000 + r * 16, 1));
            send_row(r, 1'b1, 1'b1, psum_of(7000 + r * 16, 1));
        end
        wa = last_acc;
        for (int r = 0; r < 16; r++) exp_q.push_back(acc_of(-3000 - r * 16, -1));
        for (int r = 0; r < 15; r++) send_row(r, 1'b1, 1'b1, psum_of(-3000 - r * 16, -1));
        for (int i = 0; i < 10 && cyc < wa + 17; i++) tick();
        send_row(15, 1'b1, 1'b1, psum_of(-3000 - 15 * 16, -1));
        wb = last_acc;
        checks++;
        if (wb != wa + 17) begin errors++; $display("FAIL row15_close_cycle: got %0d expected %0d", wb, wa + 17); end
        wait_start(sa, ok);
        checks++;
        if (!ok || sa != wa + 1) begin errors++; $display("FAIL row15_start_a: got cycle %0d expected %0d", sa, wa + 1); end
        wait_start(sb, ok);
        checks++;
        if (!ok || sb != wb + 1) begin errors++; $display("FAIL row15_start_b: got cycle %0d expected %0d", sb, wb + 1); end
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL row15_drain: got %0d rows left expected 0", exp_q.size()); end
    endtask

    initial begin
        rst              = 1'b1;
        bus.i_psum_valid = 1'b0;
        bus.i_psum_row   = 4'd0;
        bus.i_psum_first = 1'b0;
        bus.i_psum_last  = 1'b0;
        bus.i_psum_data  = '0;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_saturation();
        test_back_to_back();
        test_reset_mid_stream();
        test_close_on_row15();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_rows: got %0d expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
